// File: rtl/term_cfg_pkg.sv
// term_cfg_pkg
// Shared constants and helpers for the column-terminator configuration repeater.
//   CRC_POLY / CRC_INIT : CRC-16-CCITT parameters used for the frame-data CRC
//   CRC_DATA_MAX        : widest data word crc16_word can absorb in one call
//   STAGES_MAX          : deepest legal repeater pipeline
//   crc16_word()        : absorbs the low data_w bits of a word, MSB first
package term_cfg_pkg;

    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam int          CRC_DATA_MAX = 256;
    localparam int          STAGES_MAX   = 4;

    // Unrolled bit-serial CRC. The data word is right-aligned in a fixed-width
    // argument so one function serves every DATA_W; bits at or above data_w
    // are skipped, which keeps the MSB-first ordering of the real word.
    function automatic logic [15:0] crc16_word(
        input logic [15:0]             crc,
        input logic [CRC_DATA_MAX-1:0] data,
        input int                      data_w
    );
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = CRC_DATA_MAX - 1; i >= 0; i--) begin
            if (i < data_w) begin
                fb = c[15] ^ data[i];
                c  = {c[14:0], 1'b0};
                if (fb) begin
                    c = c ^ CRC_POLY;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/term_cfg_pipe_stage.sv
// term_cfg_pipe_stage
// One register stage of the configuration repeater, carrying {strobe, data}.
//   clk   : configuration clock
//   rst_n : asynchronous active-low reset, clears the stage
//   flush : synchronous clear, drops whatever is being loaded
//   d     : packed {strobe, data} from the previous stage
//   q     : registered {strobe, data}
module term_cfg_pipe_stage #(
    parameter int WIDTH = 52
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Loads every cycle so data and strobe stay aligned; flush empties the
    // stage rather than letting the current input through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/term_cfg_pipe.sv
// term_cfg_pipe
// Configuration-chain repeater for column terminator tiles. Re-times
// FrameData/FrameStrobe through 0..4 register stages and keeps frame status.
// Optional feature macro: TERM_CFG_CRC_EN (running CRC-16-CCITT of accepted
// frame data on CrcOut; when undefined CrcOut is tied to zero).
// Ports:
//   UserCLK       : configuration/user clock
//   ResetN        : asynchronous active-low reset
//   FrameData     : incoming frame data word
//   FrameStrobe   : incoming frame strobes (nominally one-hot or zero)
//   Flush         : synchronous clear of pipeline and status
//   FrameData_O   : repeated frame data
//   FrameStrobe_O : repeated frame strobes
//   UserCLKo      : UserCLK passed through, unregistered
//   FrameCount    : saturating count of accepted strobe cycles
//   StrobeErr     : sticky flag, multiple strobe bits seen in one accepted cycle
//   Busy          : a strobe is held in one of the stage registers
//   CrcOut        : running frame-data CRC
module term_cfg_pipe
    import term_cfg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int STROBE_W = 20,
    parameter int STAGES   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                UserCLK,
    input  logic                ResetN,
    input  logic [DATA_W-1:0]   FrameData,
    input  logic [STROBE_W-1:0] FrameStrobe,
    input  logic                Flush,
    output logic [DATA_W-1:0]   FrameData_O,
    output logic [STROBE_W-1:0] FrameStrobe_O,
    output logic                UserCLKo,
    output logic [CNT_W-1:0]    FrameCount,
    output logic                StrobeErr,
    output logic                Busy,
    output logic [15:0]         CrcOut
);

    localparam int PW = STROBE_W + DATA_W;

    if (STAGES < 0 || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("term_cfg_pipe: STAGES must be within 0..%0d", STAGES_MAX);
    end

    logic accepted;
    logic multi_hot;

    assign UserCLKo  = UserCLK;
    assign accepted  = (|FrameStrobe) && !Flush;
    // x & (x-1) clears the lowest set bit; anything left means 2+ bits set.
    assign multi_hot = |(FrameStrobe & (FrameStrobe - STROBE_W'(1)));

    if (STAGES == 0) begin : g_passthrough
        // Gating with ResetN keeps strobes off the fabric during reset even
        // without a register in the path.
        assign FrameData_O   = ResetN ? FrameData : '0;
        assign FrameStrobe_O = (ResetN && !Flush) ? FrameStrobe : '0;
        assign Busy          = 1'b0;
    end else begin : g_pipe
        logic [PW-1:0] pipe [STAGES+1];

        assign pipe[0] = {FrameStrobe, FrameData};

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            term_cfg_pipe_stage #(
                .WIDTH(PW)
            ) u_stage (
                .clk  (UserCLK),
                .rst_n(ResetN),
                .flush(Flush),
                .d    (pipe[i]),
                .q    (pipe[i+1])
            );
        end

        assign {FrameStrobe_O, FrameData_O} = pipe[STAGES];

        always_comb begin
            Busy = 1'b0;
            for (int i = 1; i <= STAGES; i++) begin
                Busy = Busy | (|pipe[i][PW-1:DATA_W]);
            end
        end
    end

    // Saturating frame counter; stops at all-ones instead of wrapping.
    always_ff @(posedge UserCLK or negedge ResetN) begin
        if (!ResetN) begin
            FrameCount <= '0;
        end else if (Flush) begin
            FrameCount <= '0;
        end else if (accepted && !(&FrameCount)) begin
            FrameCount <= FrameCount + CNT_W'(1);
        end
    end

    always_ff @(posedge UserCLK or negedge ResetN) begin
        if (!ResetN) begin
            StrobeErr <= 1'b0;
        end else if (Flush) begin
            StrobeErr <= 1'b0;
        end else if (accepted && multi_hot) begin
            StrobeErr <= 1'b1;
        end
    end

`ifdef TERM_CFG_CRC_EN
    logic [CRC_DATA_MAX-1:0] crc_data;
    logic [15:0]             crc_q;

    if (DATA_W > CRC_DATA_MAX) begin : g_bad_crc_width
        $error("term_cfg_pipe: DATA_W exceeds CRC_DATA_MAX");
    end

    always_comb begin
        crc_data               = '0;
        crc_data[DATA_W-1:0]   = FrameData;
    end

    // Whole word absorbed per accepted cycle, so CrcOut trails the input by
    // one edge and matches the loader's CRC over all words sent so far.
    always_ff @(posedge UserCLK or negedge ResetN) begin
        if (!ResetN) begin
            crc_q <= CRC_INIT;
        end else if (Flush) begin
            crc_q <= CRC_INIT;
        end else if (accepted) begin
            crc_q <= crc16_word(crc_q, crc_data, DATA_W);
        end
    end

    assign CrcOut = crc_q;
`else
    assign CrcOut = 16'h0000;
`endif

endmodule

// File: tb/tb_term_cfg_pipe.sv
// tb_term_cfg_pipe
// Drives three repeaters (STAGES=2/CNT_W=4, STAGES=3, STAGES=0) from the same
// inputs and compares them with a history-based reference model.
module tb_term_cfg_pipe;

`ifdef TERM_CFG_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic [19:0] strobe_in;
    logic        flush_in;

    logic [31:0] data_a, data_b, data_z;
    logic [19:0] strobe_a, strobe_b, strobe_z;
    logic        clko_a, clko_b, clko_z;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b, cnt_z;
    logic        err_a, err_b, err_z;
    logic        busy_a, busy_b, busy_z;
    logic [15:0] crc_a, crc_b, crc_z;

    logic [31:0] obs_data   [NDUT];
    logic [19:0] obs_strobe [NDUT];
    logic [15:0] obs_cnt    [NDUT];
    logic        obs_err    [NDUT];
    logic        obs_busy   [NDUT];
    logic [15:0] obs_crc    [NDUT];
    logic        obs_clko   [NDUT];

    // Reference model: per-cycle input history plus status registers.
    logic [31:0] h_data   [$];
    logic [19:0] h_strobe [$];
    bit          h_kill   [$];
    int          exp_cnt  [NDUT];
    bit          exp_err;
    logic [15:0] exp_crc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    term_cfg_pipe #(.DATA_W(32), .STROBE_W(20), .STAGES(2), .CNT_W(4)) dut_a (
        .UserCLK(clk), .ResetN(rst_n), .FrameData(data_in), .FrameStrobe(strobe_in),
        .Flush(flush_in), .FrameData_O(data_a), .FrameStrobe_O(strobe_a), .UserCLKo(clko_a),
        .FrameCount(cnt_a), .StrobeErr(err_a), .Busy(busy_a), .CrcOut(crc_a));

    term_cfg_pipe #(.DATA_W(32), .STROBE_W(20), .STAGES(3), .CNT_W(16)) dut_b (
        .UserCLK(clk), .ResetN(rst_n), .FrameData(data_in), .FrameStrobe(strobe_in),
        .Flush(flush_in), .FrameData_O(data_b), .FrameStrobe_O(strobe_b), .UserCLKo(clko_b),
        .FrameCount(cnt_b), .StrobeErr(err_b), .Busy(busy_b), .CrcOut(crc_b));

    term_cfg_pipe #(.DATA_W(32), .STROBE_W(20), .STAGES(0), .CNT_W(16)) dut_z (
        .UserCLK(clk), .ResetN(rst_n), .FrameData(data_in), .FrameStrobe(strobe_in),
        .Flush(flush_in), .FrameData_O(data_z), .FrameStrobe_O(strobe_z), .UserCLKo(clko_z),
        .FrameCount(cnt_z), .StrobeErr(err_z), .Busy(busy_z), .CrcOut(crc_z));

    assign obs_data[0] = data_a;   assign obs_data[1] = data_b;   assign obs_data[2] = data_z;
    assign obs_strobe[0] = strobe_a; assign obs_strobe[1] = strobe_b; assign obs_strobe[2] = strobe_z;
    assign obs_cnt[0] = {12'h000, cnt_a}; assign obs_cnt[1] = cnt_b; assign obs_cnt[2] = cnt_z;
    assign obs_err[0] = err_a;     assign obs_err[1] = err_b;     assign obs_err[2] = err_z;
    assign obs_busy[0] = busy_a;   assign obs_busy[1] = busy_b;   assign obs_busy[2] = busy_z;
    assign obs_crc[0] = crc_a;     assign obs_crc[1] = crc_b;     assign obs_crc[2] = crc_z;
    assign obs_clko[0] = clko_a;   assign obs_clko[1] = clko_b;   assign obs_clko[2] = clko_z;

    function automatic int st(input int d);
        return (d == 0) ? 2 : (d == 1) ? 3 : 0;
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    function automatic logic [15:0] crc_reset_val();
        return CRC_EN ? 16'hFFFF : 16'h0000;
    endfunction

    // Byte-oriented CRC-16-CCITT (0x1021), word taken most significant byte first.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) begin
            r = r ^ {w[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) begin
                r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
            end
        end
        return r;
    endfunction

    // A word entered S cycles ago reaches the output unless a flush/reset
    // happened in its entry cycle or any cycle since.
    function automatic bit alive(input int k);
        int c;
        c = h_kill.size();
        if (k < 0) return 1'b0;
        for (int j = k; j < c; j++) begin
            if (h_kill[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [19:0] m_strobe(input int d);
        if (!rst_n) return '0;
        if (st(d) == 0) return flush_in ? 20'h0 : strobe_in;
        if (!alive(h_strobe.size() - st(d))) return '0;
        return h_strobe[h_strobe.size() - st(d)];
    endfunction

    function automatic logic [31:0] m_data(input int d);
        if (!rst_n) return '0;
        if (st(d) == 0) return data_in;
        if (!alive(h_data.size() - st(d))) return '0;
        return h_data[h_data.size() - st(d)];
    endfunction

    function automatic logic m_busy(input int d);
        logic b;
        b = 1'b0;
        if (!rst_n) return 1'b0;
        for (int k = h_strobe.size() - st(d); k < h_strobe.size(); k++) begin
            if (alive(k) && (|h_strobe[k])) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [15:0] m_cnt(input int d);
        return rst_n ? 16'(exp_cnt[d]) : 16'h0;
    endfunction

    function automatic logic m_err();
        return rst_n ? exp_err : 1'b0;
    endfunction

    function automatic logic [15:0] m_crc();
        return rst_n ? exp_crc : crc_reset_val();
    endfunction

    task automatic drive(input logic [31:0] d, input logic [19:0] s, input logic f);
        data_in   = d;
        strobe_in = s;
        flush_in  = f;
    endtask

    // Advance one clock edge and update the model with the inputs seen there.
    task automatic tick();
        bit kill;
        @(posedge clk);
        kill = !rst_n || flush_in;
        h_data.push_back(data_in);
        h_strobe.push_back(strobe_in);
        h_kill.push_back(kill);
        if (kill) begin
            for (int d = 0; d < NDUT; d++) exp_cnt[d] = 0;
            exp_err = 1'b0;
            exp_crc = crc_reset_val();
        end else if (|strobe_in) begin
            for (int d = 0; d < NDUT; d++) begin
                if (exp_cnt[d] < cnt_max(d)) exp_cnt[d]++;
            end
            if ($countones(strobe_in) > 1) exp_err = 1'b1;
            if (CRC_EN) exp_crc = crc_ref(exp_crc, data_in);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'hFFFF_FFFF, 20'h00010, 1'b0);
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                n_checks += 6;
                if (obs_strobe[d] !== 20'h0) begin n_fail++; $display("[TB] FAIL rst_strobe dut%0d: got %h want 0", d, obs_strobe[d]); end
                if (obs_data[d] !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_data dut%0d: got %h want 0", d, obs_data[d]); end
                if (obs_cnt[d] !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_cnt dut%0d: got %h want 0", d, obs_cnt[d]); end
                if (obs_err[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err dut%0d: got %b want 0", d, obs_err[d]); end
                if (obs_busy[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy dut%0d: got %b want 0", d, obs_busy[d]); end
                if (obs_crc[d] !== crc_reset_val()) begin n_fail++; $display("[TB] FAIL rst_crc dut%0d: got %h want %h", d, obs_crc[d], crc_reset_val()); end
            end
            tick();
        end
        rst_n = 1'b1;
        drive('0, '0, 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (obs_clko[d] !== 1'b1) begin n_fail++; $display("[TB] FAIL clko_high dut%0d: got %b want 1", d, obs_clko[d]); end
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (obs_clko[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL clko_low dut%0d: got %b want 0", d, obs_clko[d]); end
        end
        tick();
    endtask

    task automatic test_latency();
        logic [19:0] es;
        logic [31:0] ed;
        drive('0, '0, 1'b1);
        tick();
        drive(32'hDEAD_BEEF, 20'h00001, 1'b0);
        for (int o = 0; o < 5; o++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                es = (o == st(d)) ? 20'h00001 : 20'h0;
                ed = (o == st(d)) ? 32'hDEAD_BEEF : 32'h0;
                n_checks += 4;
                if (obs_strobe[d] !== es) begin n_fail++; $display("[TB] FAIL lat_strobe dut%0d o=%0d: got %h want %h", d, o, obs_strobe[d], es); end
                if (obs_data[d] !== ed) begin n_fail++; $display("[TB] FAIL lat_data dut%0d o=%0d: got %h want %h", d, o, obs_data[d], ed); end
                if (obs_busy[d] !== (o >= 1 && o <= st(d))) begin n_fail++; $display("[TB] FAIL lat_busy dut%0d o=%0d: got %b want %b", d, o, obs_busy[d], (o >= 1 && o <= st(d))); end
                if (obs_cnt[d] !== ((o >= 1) ? 16'h1 : 16'h0)) begin n_fail++; $display("[TB] FAIL lat_cnt dut%0d o=%0d: got %h want %0d", d, o, obs_cnt[d], (o >= 1)); end
            end
            tick();
            drive('0, '0, 1'b0);
        end
    endtask

    task automatic test_strobe_err();
        drive('0, '0, 1'b1);
        tick();
        drive(32'h1234_5678, 20'h00003, 1'b0);
        for (int o = 0; o < 6; o++) begin
            if (o == 5) drive('0, '0, 1'b1);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                n_checks += 2;
                if (obs_err[d] !== (o >= 1)) begin n_fail++; $display("[TB] FAIL err_sticky dut%0d o=%0d: got %b want %b", d, o, obs_err[d], (o >= 1)); end
                if (obs_strobe[d] !== ((o == st(d)) ? 20'h00003 : 20'h0)) begin n_fail++; $display("[TB] FAIL err_strobe dut%0d o=%0d: got %h", d, o, obs_strobe[d]); end
            end
            tick();
            if (o < 5) drive('0, '0, 1'b0);
        end
        drive('0, '0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks += 2;
            if (obs_err[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL err_flush dut%0d: got %b want 0", d, obs_err[d]); end
            if (obs_cnt[d] !== 16'h0) begin n_fail++; $display("[TB] FAIL err_flush_cnt dut%0d: got %h want 0", d, obs_cnt[d]); end
        end
        tick();
    endtask

    task automatic test_saturation();
        int want;
        drive('0, '0, 1'b1);
        tick();
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) drive($urandom, 20'h1 << $urandom_range(0, 19), 1'b0);
            else        drive('0, '0, 1'b0);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                want = (i < cnt_max(d)) ? i : cnt_max(d);
                n_checks++;
                if (obs_cnt[d] !== 16'(want)) begin n_fail++; $display("[TB] FAIL sat_cnt dut%0d i=%0d: got %0d want %0d", d, i, obs_cnt[d], want); end
            end
            tick();
        end
    endtask

    task automatic test_flush_with_strobe();
        drive('0, '0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + 32'(i), 20'h1 << i, 1'b0);
            tick();
        end
        drive(32'hAAAA_5555, 20'h00008, 1'b1);
        @(negedge clk);
        n_checks++;
        if (obs_strobe[2] !== 20'h0) begin n_fail++; $display("[TB] FAIL flush_comb_strobe: got %h want 0", obs_strobe[2]); end
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (obs_cnt[d] !== 16'h3) begin n_fail++; $display("[TB] FAIL flush_cnt_hold dut%0d: got %0d want 3", d, obs_cnt[d]); end
        end
        tick();
        drive('0, '0, 1'b0);
        for (int o = 0; o < 4; o++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                n_checks += 3;
                if (obs_strobe[d] !== 20'h0) begin n_fail++; $display("[TB] FAIL flush_strobe dut%0d o=%0d: got %h want 0", d, o, obs_strobe[d]); end
                if (obs_cnt[d] !== 16'h0) begin n_fail++; $display("[TB] FAIL flush_cnt dut%0d o=%0d: got %0d want 0", d, o, obs_cnt[d]); end
                if (obs_busy[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy dut%0d o=%0d: got %b want 0", d, o, obs_busy[d]); end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        drive('0, '0, 1'b1);
        tick();
        drive(32'h5555_AAAA, 20'h00004, 1'b0);
        for (int o = 0; o < 7; o++) begin
            if (o == 1) begin
                drive('0, '0, 1'b0);
                rst_n = 1'b0;
            end
            if (o == 3) rst_n = 1'b1;
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!(d == 2 && o == 0)) begin
                    n_checks++;
                    if (obs_strobe[d] !== 20'h0) begin n_fail++; $display("[TB] FAIL mrst_strobe dut%0d o=%0d: got %h want 0", d, o, obs_strobe[d]); end
                end
                if (o >= 1) begin
                    n_checks += 3;
                    if (obs_data[d] !== 32'h0) begin n_fail++; $display("[TB] FAIL mrst_data dut%0d o=%0d: got %h want 0", d, o, obs_data[d]); end
                    if (obs_cnt[d] !== 16'h0) begin n_fail++; $display("[TB] FAIL mrst_cnt dut%0d o=%0d: got %0d want 0", d, o, obs_cnt[d]); end
                    if (obs_busy[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL mrst_busy dut%0d o=%0d: got %b want 0", d, o, obs_busy[d]); end
                end
            end
            tick();
        end
    endtask

    task automatic test_crc();
        logic [15:0] want0;
        want0 = CRC_EN ? 16'h84C0 : 16'h0000;
        drive('0, '0, 1'b1);
        tick();
        drive(32'h0000_0000, 20'h00020, 1'b0);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (obs_crc[d] !== crc_reset_val()) begin n_fail++; $display("[TB] FAIL crc_init dut%0d: got %h want %h", d, obs_crc[d], crc_reset_val()); end
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive($urandom, (i == 2) ? 20'h0 : 20'h00040, 1'b0);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (i == 0 && obs_crc[d] !== want0) begin n_fail++; $display("[TB] FAIL crc_zero_word dut%0d: got %h want %h", d, obs_crc[d], want0); end
                if (i > 0 && obs_crc[d] !== m_crc()) begin n_fail++; $display("[TB] FAIL crc_run dut%0d i=%0d: got %h want %h", d, i, obs_crc[d], m_crc()); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int          r;
        logic [19:0] s;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      s = 20'h0;
            else if (r < 25) s = 20'($urandom);
            else             s = 20'h1 << $urandom_range(0, 19);
            drive($urandom, s, $urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                n_checks += 6;
                if (obs_strobe[d] !== m_strobe(d)) begin n_fail++; $display("[TB] FAIL rnd_strobe dut%0d i=%0d: got %h want %h", d, i, obs_strobe[d], m_strobe(d)); end
                if (obs_data[d] !== m_data(d)) begin n_fail++; $display("[TB] FAIL rnd_data dut%0d i=%0d: got %h want %h", d, i, obs_data[d], m_data(d)); end
                if (obs_busy[d] !== m_busy(d)) begin n_fail++; $display("[TB] FAIL rnd_busy dut%0d i=%0d: got %b want %b", d, i, obs_busy[d], m_busy(d)); end
                if (obs_cnt[d] !== m_cnt(d)) begin n_fail++; $display("[TB] FAIL rnd_cnt dut%0d i=%0d: got %0d want %0d", d, i, obs_cnt[d], m_cnt(d)); end
                if (obs_err[d] !== m_err()) begin n_fail++; $display("[TB] FAIL rnd_err dut%0d i=%0d: got %b want %b", d, i, obs_err[d], m_err()); end
                if (obs_crc[d] !== m_crc()) begin n_fail++; $display("[TB] FAIL rnd_crc dut%0d i=%0d: got %h want %h", d, i, obs_crc[d], m_crc()); end
            end
            tick();
        end
        rst_n = 1'b1;
        drive('0, '0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) exp_cnt[d] = 0;
        exp_err = 1'b0;
        exp_crc = crc_reset_val();
        rst_n   = 1'b0;
        drive('0, '0, 1'b0);
        tick();
        test_reset();
        test_latency();
        test_strobe_err();
        test_saturation();
        test_flush_with_strobe();
        test_mid_reset();
        test_crc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/term_cfg_pipe.md
Name: term_cfg_pipe

Overview:
Parametrised configuration-chain repeater for column terminator tiles (N/S term of DSP, RAM and CLB columns).
- Replaces the bare per-bit FrameData/FrameStrobe buffers with 0..4 register stages, so tall columns close timing on the configuration path.
- Adds frame accounting, strobe-integrity checking and a flush control.
- Sits between the frame-address decoder output and the first fabric tile of a column.

Parameters:
DATA_W, 32, FrameData width per row.
STROBE_W, 20, FrameStrobe width (frames per column).
STAGES, 1, pipeline depth, legal 0..4; 0 = combinational passthrough.
CNT_W, 16, FrameCount width.

Ports:
UserCLK  in  1  configuration/user clock.
ResetN  in  1  asynchronous active-low reset.
FrameData  in  DATA_W  incoming frame data word.
FrameStrobe  in  STROBE_W  incoming frame strobes; nominally one-hot or zero.
Flush  in  1  synchronous clear of pipeline and status.
FrameData_O  out  DATA_W  repeated frame data.
FrameStrobe_O  out  STROBE_W  repeated frame strobes.
UserCLKo  out  1  UserCLK through clock buffer, unregistered.
FrameCount  out  CNT_W  number of accepted strobe cycles, saturating.
StrobeErr  out  1  sticky: more than one strobe bit seen high in a cycle.
Busy  out  1  a strobe is in flight inside the pipeline.
CrcOut  out  16  running frame-data CRC (see Optional Feature).

Behaviour:
- Reset (ResetN=0, async): all stage registers 0; FrameData_O=0; FrameStrobe_O=0; FrameCount=0; StrobeErr=0; Busy=0; CrcOut=16'hFFFF (feature on) or 0 (feature off). No strobe may reach the fabric during or immediately after reset.
- Accepted cycle: |FrameStrobe=1 and Flush=0.
- Pipeline, STAGES>=1:
  - Data and strobe registers load every cycle; data is not gated by strobe, so the two stay aligned.
  - Latency is exactly STAGES cycles.
  - Strobe vectors with multiple bits set propagate unmodified.
- STAGES=0: outputs are combinational copies of the inputs; Busy is tied 0. All status logic remains registered.
- Flush=1 (synchronous):
  - Next cycle: all stage registers, FrameCount and StrobeErr are 0, and CRC is at its init value.
  - The input strobe in the flush cycle is dropped: not piped, not counted, not checked, not added to CRC.
  - With STAGES=0, FrameStrobe_O is forced to 0 while Flush=1.
- FrameCount: +1 on each accepted cycle; holds at 2^CNT_W-1 on saturation (no wrap).
- StrobeErr: set in the cycle after an accepted cycle with popcount(FrameStrobe)>1; cleared only by reset or Flush.
- Busy: OR over the strobe bits of all stage registers.
- Reset asserted mid-frame: in-flight strobes are discarded; FrameStrobe_O returns to 0 asynchronously.

Optional Feature:
Macro TERM_CFG_CRC_EN.
- Defined: on each accepted cycle, CRC-16-CCITT (poly 16'h1021, init 16'hFFFF, no reflection, no final XOR) absorbs FrameData, MSB first, all DATA_W bits in one cycle (unrolled). CrcOut is registered and includes words up to the previous clock edge. The bitstream loader compares CrcOut against its own CRC.
- Undefined: no CRC logic is generated; CrcOut is tied to 16'h0000.

Decomposition:
- Package term_cfg_pkg:
  - CRC_POLY and CRC_INIT constants.
  - Function crc16_word(crc, data) parameterised on DATA_W.
  - STAGES_MAX=4 constant, used by an elaboration-time range check.
- Sub-module term_cfg_pipe_stage: one register stage carrying {strobe, data}, with async reset and sync flush. It is instantiated STAGES times via generate.

Test Plan:
- STAGES=2; drive FrameData=32'hDEADBEEF, FrameStrobe=20'h00001 for 1 cycle -> FrameData_O/FrameStrobe_O show exactly those values 2 cycles later; Busy=1 for 2 cycles; FrameCount=1.
- FrameStrobe=20'h00003 for 1 cycle -> StrobeErr=1 on the next cycle and stays 1; strobe still appears at the output after STAGES cycles; Flush pulse -> StrobeErr=0.
- CNT_W=4; 20 consecutive accepted cycles -> FrameCount stops at 15.
- STAGES=3; strobe at cycle 0, ResetN low at cycle 1 -> FrameStrobe_O=0 throughout; after release, outputs, count and Busy are 0.
- Flush asserted together with a strobe -> output stays 0; FrameCount is unchanged, then 0 after the flush.
- TERM_CFG_CRC_EN; DATA_W=32; single accepted word 32'h00000000 from init -> CrcOut equals the CCITT-FALSE CRC of four zero bytes, 16'h84C0. Without the macro -> CrcOut=0 always.
